exit_status_uart_reporter: RTL and testbench
============================================

Name: exit_status_uart_reporter

Overview:
- Downstream consumer of the MCU system's exit_valid/exit_value outputs in the FPGA top wrapper.
- On a program exit, latches the full 32-bit exit value and transmits it over a dedicated UART TX pin as the ASCII line "EXIT=XXXXXXXX\r\n" (uppercase hex, MSB nibble first).
- Drives a pass LED (exit value == 0) and a done LED, so board runs report status without a debugger.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 2.
- MSG_LEN, 15, characters per report line; fixed by the package constant and not overridable.

Ports:
- clk_i  in  1  system clock (same clock as the MCU system).
- rst_ni  in  1  reset, synchronous, active-low.
- exit_valid_i  in  1  exit-valid flag from the MCU system; level signal.
- exit_value_i  in  32  exit value from the MCU system.
- tx_o  out  1  UART TX line, 8N1, LSB first, idle high.
- busy_o  out  1  high while a report line is being transmitted.
- done_o  out  1  sticky; high after a complete line has been sent.
- pass_o  out  1  sticky; high with done_o when the latched value == 0.

Behaviour:
- Reset (rst_ni low at a clk_i edge): tx_o=1, busy_o=0, done_o=0, pass_o=0. Internal state is cleared: FSM=IDLE, counters=0, latched value=0, exit_valid history=0. Reset takes effect on the next edge, including mid-frame; tx_o returns high on that edge.
- Trigger is the rising edge of exit_valid_i: registered previous sample is 0 and the current sample is 1.
  - A trigger in IDLE or DONE latches exit_value_i in that same cycle (cycle N).
  - At that edge: clears done_o and pass_o, sets busy_o, and enters START.
  - tx_o goes low at cycle N+1.
- Triggers while busy_o=1 are ignored, and the latched value is not altered.
- exit_valid_i held high produces exactly one report.
- FSM states: IDLE -> START -> DATA (8 bits) -> STOP -> either next character's START, or DONE after the 15th character. DONE -> START on a new trigger.
- Bit timing: each bit is held for exactly CLKS_PER_BIT cycles. Character frame = 10*CLKS_PER_BIT cycles. There is no gap between characters.
- The full line takes 150*CLKS_PER_BIT cycles: tx_o low at N+1, last stop bit ends at N+150*CLKS_PER_BIT.
- Completion: busy_o falls and done_o rises at cycle N+1+150*CLKS_PER_BIT. pass_o is set at the same cycle iff latched==0.
- Character index 0..14:
  - Indices 0..4 are "EXIT=" (0x45,0x58,0x49,0x54,0x3D).
  - Indices 5..12 are nibbles [31:28] down to [3:0] of the latched value. Nibble 0-9 maps to 0x30+n; nibble 10-15 maps to 0x41+(n-10).
  - Indices 13 and 14 are 0x0D and 0x0A.
- Index and bit counters wrap to 0 only through the FSM transition and never overflow. The baud counter width is $clog2(CLKS_PER_BIT).
- Changes on exit_value_i after the latch have no effect on the line being sent.

Decomposition:
- Package exit_status_uart_reporter_pkg contains:
  - MSG_LEN=15, HDR_LEN=5.
  - Character constants for 'E','X','I','T','=', CR, LF.
  - FSM state enum {IDLE, START, DATA, STOP, DONE}.
  - A function nibble_to_ascii(logic [3:0]) returning logic [7:0].
- Sub-module exit_uart_byte_tx implements a single-byte 8N1 serializer.
  - Ports: clk_i, rst_ni, valid_i, data_i[7:0], ready_o, tx_o.
  - Parameterised by CLKS_PER_BIT.
  - When ready_o and valid_i are both high, it accepts the byte and starts the start bit on the next cycle.
  - ready_o re-asserts in the last cycle of the stop bit so back-to-back characters have no gap.
- The top module holds the trigger edge detector, value latch, character index, the message mux, and the done/pass flags.

Test Plan:
- CLKS_PER_BIT=4, exit_value_i=0x0000002A, pulse exit_valid_i -> tx_o decodes to "EXIT=0000002A\r\n". First frame is start, 1,0,1,0,0,0,1,0, stop. done_o=1 exactly 601 cycles after the trigger edge; pass_o=0.
- exit_value_i=0x00000000 with exit_valid_i held high for 2000 cycles -> exactly one line "EXIT=00000000\r\n"; done_o=1 and pass_o=1; no second transmission.
- exit_value_i=0xDEADBEEF; change input to 0x12345678 at trigger+10 and re-pulse exit_valid_i at trigger+100 -> line is "EXIT=DEADBEEF\r\n" (uppercase) and the retrigger is ignored.
- After done_o, retrigger with value 0x00000001 -> done_o and pass_o clear on the trigger edge; new line "EXIT=00000001\r\n"; done_o=1 and pass_o=0.
- Assert rst_ni low at trigger+200 (mid-character) -> next edge gives tx_o=1, busy_o=0, done_o=0. After release, tx_o stays idle-high until a new rising edge of exit_valid_i.
- CLKS_PER_BIT=2 boundary: trigger with value 0xF0F0F0F0 -> "EXIT=F0F0F0F0\r\n" with bit period 2 cycles; total 300 cycles from tx_o falling to done_o.

Source files
------------

// File: rtl/exit_status_uart_reporter_pkg.sv
// Shared constants, FSM state type and hex-to-ASCII helper for the exit status reporter.
package exit_status_uart_reporter_pkg;

  localparam int MSG_LEN = 15;
  localparam int HDR_LEN = 5;

  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_X  = 8'h58;
  localparam logic [7:0] CH_I  = 8'h49;
  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_e;

  // Uppercase hex digit: 0-9 -> '0'..'9', 10-15 -> 'A'..'F' (0x41 - 10 = 0x37).
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/exit_uart_byte_tx.sv
// Single-byte 8N1 UART serializer; ready rises in the final stop-bit cycle so
// the next byte follows with no idle gap.
module exit_uart_byte_tx
  import exit_status_uart_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  state_e            r_state;
  state_e            w_state_next;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_next;
  logic [2:0]        r_bit;
  logic [2:0]        w_bit_next;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_next;
  logic              r_tx;
  logic              w_tx_next;
  logic              w_bit_end;
  logic              w_accept;

  assign w_bit_end = (r_baud == BAUD_LAST);
  assign ready_o   = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);
  assign w_accept  = ready_o && valid_i;
  assign tx_o      = r_tx;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    if (w_accept) begin
      w_state_next = START;
      w_baud_next  = '0;
      w_bit_next   = '0;
      w_shift_next = data_i;
      w_tx_next    = 1'b0;
    end else begin
      case (r_state)
        START: begin
          if (w_bit_end) begin
            w_state_next = DATA;
            w_baud_next  = '0;
            w_tx_next    = r_shift[0];
          end else begin
            w_baud_next = r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            w_baud_next = '0;
            if (r_bit == 3'd7) begin
              w_state_next = STOP;
              w_tx_next    = 1'b1;
            end else begin
              w_bit_next   = r_bit + 3'd1;
              w_shift_next = {1'b0, r_shift[7:1]};
              w_tx_next    = r_shift[1];
            end
          end else begin
            w_baud_next = r_baud + 1'b1;
          end
        end
        STOP: begin
          // Reaching the end here means no follow-on byte was offered.
          if (w_bit_end) begin
            w_state_next = IDLE;
            w_baud_next  = '0;
          end else begin
            w_baud_next = r_baud + 1'b1;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_tx_next    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/exit_status_uart_reporter.sv
// Reports the MCU exit value as "EXIT=XXXXXXXX\r\n" over UART and drives
// sticky done/pass status flags.
module exit_status_uart_reporter
  import exit_status_uart_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o
);

  logic        r_valid_prev;
  logic [31:0] r_value;
  logic [3:0]  r_idx;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;

  logic        w_trig;
  logic        w_last;
  logic        w_ready;
  logic        w_valid;
  logic [3:0]  w_send_idx;
  logic [2:0]  w_hex_sel;
  logic [7:0]  w_char;
  logic [7:0]  w_hex_char [8];

  assign w_trig     = exit_valid_i && !r_valid_prev && !r_busy;
  assign w_last     = (r_idx == 4'(MSG_LEN - 1));
  assign w_valid    = w_trig || (r_busy && w_ready && !w_last);
  // The first character is a constant, so it can be offered before the value latch settles.
  assign w_send_idx = w_trig ? 4'd0 : r_idx + 4'd1;
  assign w_hex_sel  = 3'(w_send_idx - 4'(HDR_LEN));

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_hex
      assign w_hex_char[gi] = nibble_to_ascii(r_value[31-4*gi -: 4]);
    end
  endgenerate

  always_comb begin
    w_char = CH_LF;
    case (w_send_idx)
      4'd0:    w_char = CH_E;
      4'd1:    w_char = CH_X;
      4'd2:    w_char = CH_I;
      4'd3:    w_char = CH_T;
      4'd4:    w_char = CH_EQ;
      4'd13:   w_char = CH_CR;
      4'd14:   w_char = CH_LF;
      default: w_char = w_hex_char[w_hex_sel];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid_prev <= 1'b0;
      r_value      <= '0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_valid_prev <= exit_valid_i;
      if (w_trig) begin
        r_value <= exit_value_i;
        r_idx   <= '0;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
        r_pass  <= 1'b0;
      end else if (r_busy && w_ready) begin
        if (w_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_pass <= (r_value == 32'd0);
          r_idx  <= '0;
        end else begin
          r_idx <= w_send_idx;
        end
      end
    end
  end

  exit_uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid_i(w_valid),
    .data_i (w_char),
    .ready_o(w_ready),
    .tx_o   (tx_o)
  );

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign pass_o = r_pass;

endmodule

// File: tb/tb_exit_status_uart_reporter.sv
// Directed and randomized checks of the exit status UART reporter against a
// cycle-level model of the expected serial line.
module tb_exit_status_uart_reporter;

  localparam int CPB_A = 4;
  localparam int CPB_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a = 1'b0;
  logic        ev_a    = 1'b0;
  logic [31:0] val_a   = 32'd0;
  logic        tx_a, busy_a, done_a, pass_a;

  logic        rst_n_b = 1'b0;
  logic        ev_b    = 1'b0;
  logic [31:0] val_b   = 32'd0;
  logic        tx_b, busy_b, done_b, pass_b;

  exit_status_uart_reporter #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .clk_i       (clk),
    .rst_ni      (rst_n_a),
    .exit_valid_i(ev_a),
    .exit_value_i(val_a),
    .tx_o        (tx_a),
    .busy_o      (busy_a),
    .done_o      (done_a),
    .pass_o      (pass_a)
  );

  exit_status_uart_reporter #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n_b),
    .exit_valid_i(ev_b),
    .exit_value_i(val_b),
    .tx_o        (tx_b),
    .busy_o      (busy_b),
    .done_o      (done_b),
    .pass_o      (pass_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed=\"%s\" (len %0d) expected=\"%s\"", tag,
             obs.substr(0, 12), obs.len(), exp.substr(0, 12));
    end
  endtask

  function automatic string exp_line(input logic [31:0] v);
    string hexd;
    string s;
    int    n;
    hexd = "0123456789ABCDEF";
    s = "EXIT=";
    for (int i = 7; i >= 0; i--) begin
      n = int'(v[4*i +: 4]);
      s = {s, hexd.substr(n, n)};
    end
    return {s, "\015\012"};
  endfunction

  function automatic logic o_tx(input int d);   return (d == 0) ? tx_a   : tx_b;   endfunction
  function automatic logic o_busy(input int d); return (d == 0) ? busy_a : busy_b; endfunction
  function automatic logic o_done(input int d); return (d == 0) ? done_a : done_b; endfunction
  function automatic logic o_pass(input int d); return (d == 0) ? pass_a : pass_b; endfunction

  task automatic set_ev(input int d, input logic v);
    if (d == 0) ev_a = v; else ev_b = v;
  endtask

  task automatic set_val(input int d, input logic [31:0] v);
    if (d == 0) val_a = v; else val_b = v;
  endtask

  // Triggers one report and checks every tx_o cycle against the expected line.
  task automatic run_line(input int d, input int cpb, input logic [31:0] v, input int hold,
                          input int chg_at, input logic [31:0] chg_val, input int rep_at,
                          input string tag);
    string       exp_s, got_s, one;
    int          total, wave_bad, busy_bad;
    int          c, pos, b;
    byte unsigned ch;
    logic        eb;
    logic [7:0]  rx;
    logic        d1, p1, dpre;
    exp_s = exp_line(v);
    got_s = "";
    one = " ";
    total = 150 * cpb;
    wave_bad = 0;
    busy_bad = 0;
    rx = 8'h00;
    d1 = 1'bx; p1 = 1'bx; dpre = 1'bx;
    set_val(d, v);
    set_ev(d, 1'b1);
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        d1 = o_done(d);
        p1 = o_pass(d);
      end
      if (k <= total) begin
        c   = (k - 1) / (10 * cpb);
        pos = (k - 1) % (10 * cpb);
        b   = pos / cpb;
        ch  = exp_s[c];
        eb  = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : ch[b-1];
        if (o_tx(d) !== eb) wave_bad++;
        if (o_busy(d) !== 1'b1) busy_bad++;
        if (b >= 1 && b <= 8 && (pos % cpb) == cpb / 2) rx[b-1] = o_tx(d);
        if (b == 9 && (pos % cpb) == cpb / 2) begin
          one.putc(0, rx);
          got_s = {got_s, one};
        end
      end
      if (k == total) dpre = o_done(d);
      if (k == hold) set_ev(d, 1'b0);
      if (k == chg_at) set_val(d, chg_val);
      if (rep_at > 0 && k == rep_at + 1) set_ev(d, 1'b1);
      if (rep_at > 0 && k == rep_at + 2) set_ev(d, 1'b0);
    end
    chk({tag, " flags_clear_on_trigger"}, 32'({d1, p1}), 32'd0);
    chk({tag, " tx_wave_mismatches"}, 32'(wave_bad), 32'd0);
    chk({tag, " busy_low_cycles"}, 32'(busy_bad), 32'd0);
    chk_str({tag, " line"}, got_s, exp_s);
    chk({tag, " done_before_end"}, 32'(dpre), 32'd0);
    chk({tag, " done_at_end"}, 32'(o_done(d)), 32'd1);
    chk({tag, " busy_at_end"}, 32'(o_busy(d)), 32'd0);
    chk({tag, " pass_at_end"}, 32'(o_pass(d)), 32'(v == 32'd0));
    $display("line %s: value=%08h cpb=%0d sent=%0d chars", tag, v, cpb, got_s.len());
  endtask

  task automatic idle_check(input int d, input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_tx(d) !== 1'b1 || o_busy(d) !== 1'b0) bad++;
    end
    chk({tag, " idle_cycles_bad"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [31:0] rv;
    int          bad;

    repeat (3) @(negedge clk);
    chk("reset tx_a", 32'(tx_a), 32'd1);
    chk("reset busy_a", 32'(busy_a), 32'd0);
    chk("reset done_a", 32'(done_a), 32'd0);
    chk("reset pass_a", 32'(pass_a), 32'd0);
    chk("reset tx_b", 32'(tx_b), 32'd1);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    repeat (3) @(negedge clk);

    run_line(0, CPB_A, 32'h0000002A, 1, -1, 32'd0, -1, "t1_2a");
    idle_check(0, 5, "t1_after");

    // Held-high valid must produce exactly one line.
    run_line(0, CPB_A, 32'h00000000, 100000, -1, 32'd0, -1, "t2_zero_held");
    idle_check(0, 1399, "t2_no_second_line");
    set_ev(0, 1'b0);
    @(negedge clk);
    chk("t2 done_sticky", 32'(done_a), 32'd1);
    chk("t2 pass_sticky", 32'(pass_a), 32'd1);
    idle_check(0, 4, "t2_after");

    run_line(0, CPB_A, 32'h00000001, 1, -1, 32'd0, -1, "t4_retrigger_one");
    idle_check(0, 5, "t4_after");

    run_line(0, CPB_A, 32'hDEADBEEF, 1, 10, 32'h12345678, 100, "t3_deadbeef");
    idle_check(0, 50, "t3_retrigger_ignored");

    // Reset in the middle of a character.
    set_val(0, 32'hCAFE0000);
    set_ev(0, 1'b1);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) set_ev(0, 1'b0);
    end
    rst_n_a = 1'b0;
    @(negedge clk);
    chk("t5 reset tx", 32'(tx_a), 32'd1);
    chk("t5 reset busy", 32'(busy_a), 32'd0);
    chk("t5 reset done", 32'(done_a), 32'd0);
    chk("t5 reset pass", 32'(pass_a), 32'd0);
    rst_n_a = 1'b1;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
    end
    chk("t5 idle_after_reset_bad", 32'(bad), 32'd0);
    $display("reset mid-line: idle cycles checked=400");

    repeat (3) begin
      rv = $urandom;
      run_line(0, CPB_A, rv, 1, -1, 32'd0, -1, "rand_a");
      idle_check(0, 3, "rand_a_after");
    end

    run_line(1, CPB_B, 32'hF0F0F0F0, 1, -1, 32'd0, -1, "t6_cpb2");
    idle_check(1, 3, "t6_after");
    repeat (2) begin
      rv = $urandom;
      run_line(1, CPB_B, rv, 1 + int'($urandom_range(0, 5)), -1, 32'd0, -1, "rand_b");
      idle_check(1, 8, "rand_b_after");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
